// File: rtl/d_cache_port_arbiter.sv
// Two-requester arbiter in front of the single-port d_cache: CPU MEM stage first,
// with a bounded starvation window for the external loader/debug master.
module d_cache_port_arbiter #(
    parameter int DPW          = 32,
    parameter int Depth        = 120,
    parameter int ExtStarveMax = 3
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           cpu_req,
    input  logic           cpu_we,
    input  logic [DPW-1:0] cpu_addr,
    input  logic [DPW-1:0] cpu_wd,
    output logic           cpu_stall,
    output logic           cpu_rvalid,
    output logic [DPW-1:0] cpu_rd,
    output logic           cpu_err,
    input  logic           ext_req,
    input  logic           ext_we,
    input  logic [DPW-1:0] ext_addr,
    input  logic [DPW-1:0] ext_wd,
    output logic           ext_gnt,
    output logic           ext_rvalid,
    output logic [DPW-1:0] ext_rd,
    output logic           ext_err,
    output logic [DPW-1:0] mem_addr,
    output logic [DPW-1:0] mem_wd,
    output logic           mem_we,
    input  logic [DPW-1:0] mem_rd
);

    localparam int             SW         = $clog2(ExtStarveMax + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(ExtStarveMax);
    localparam logic [DPW-1:0] LAST_WORD  = DPW'(Depth - 4);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    owner_t        owner;
    owner_t        rd_owner_reg, rd_owner_next;
    logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
    logic          rd_bad_reg, rd_bad_next;
    logic          cpu_err_reg, cpu_err_next;
    logic          ext_err_reg, ext_err_next;
    logic          cpu_legal, ext_legal;
    logic          sel_legal, sel_we;

    assign cpu_legal = (cpu_addr <= LAST_WORD);
    assign ext_legal = (ext_addr <= LAST_WORD);

    // A starved external request beats the CPU once its wait hits the bound.
    always_comb begin
        owner = OWN_NONE;
        if (ext_req && (starve_cnt_reg == STARVE_MAX)) begin
            owner = OWN_EXT;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (ext_req) begin
            owner = OWN_EXT;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wd    = '0;
        sel_we    = 1'b0;
        sel_legal = 1'b1;
        case (owner)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wd    = cpu_wd;
                sel_we    = cpu_we;
                sel_legal = cpu_legal;
            end
            OWN_EXT: begin
                mem_addr  = ext_addr;
                mem_wd    = ext_wd;
                sel_we    = ext_we;
                sel_legal = ext_legal;
            end
            default: ;
        endcase
        // Out-of-range accesses are accepted but must never write the array.
        mem_we = sel_we && sel_legal;
    end

    assign cpu_stall = cpu_req && (owner != OWN_CPU);
    assign ext_gnt   = (owner == OWN_EXT);

    always_comb begin
        rd_owner_next = OWN_NONE;
        rd_bad_next   = 1'b0;
        if ((owner != OWN_NONE) && !sel_we) begin
            rd_owner_next = owner;
            rd_bad_next   = !sel_legal;
        end
        cpu_err_next = (owner == OWN_CPU) && !cpu_legal;
        ext_err_next = (owner == OWN_EXT) && !ext_legal;

        starve_cnt_next = starve_cnt_reg;
        if (!ext_req || ext_gnt) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            starve_cnt_reg <= '0;
            rd_owner_reg   <= OWN_NONE;
            rd_bad_reg     <= 1'b0;
            cpu_err_reg    <= 1'b0;
            ext_err_reg    <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rd_owner_reg   <= rd_owner_next;
            rd_bad_reg     <= rd_bad_next;
            cpu_err_reg    <= cpu_err_next;
            ext_err_reg    <= ext_err_next;
        end
    end

    // mem_rd belongs to last cycle's read; only its issuer sees it, zeroed if illegal.
    assign cpu_rvalid = (rd_owner_reg == OWN_CPU);
    assign ext_rvalid = (rd_owner_reg == OWN_EXT);
    assign cpu_rd     = (cpu_rvalid && !rd_bad_reg) ? mem_rd : '0;
    assign ext_rd     = (ext_rvalid && !rd_bad_reg) ? mem_rd : '0;
    assign cpu_err    = cpu_err_reg;
    assign ext_err    = ext_err_reg;

endmodule

// File: tb/tb_d_cache_port_arbiter.sv
// Directed bench for d_cache_port_arbiter: a rule-level reference model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_d_cache_port_arbiter;

    localparam int DEPTH      = 120;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wd;
    logic        cpu_stall, cpu_rvalid, cpu_err;
    logic [31:0] cpu_rd;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wd;
    logic        ext_gnt, ext_rvalid, ext_err;
    logic [31:0] ext_rd;
    logic [31:0] mem_addr, mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd = 32'd0;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b1;

    always #5 clk = ~clk;

    d_cache_port_arbiter #(
        .DPW(32), .Depth(DEPTH), .ExtStarveMax(STARVE_MAX)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd), .cpu_err(cpu_err),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rd(ext_rd), .ext_err(ext_err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    // d_cache stand-in: byte array, registered read, garbage outside the array.
    logic [7:0] dbytes [0:255];
    always @(posedge clk) begin
        logic [7:0] b;
        b = mem_addr[7:0];
        if (mem_we && mem_addr <= 32'd252) begin
            for (int i = 0; i < 4; i++) dbytes[b + 8'(i)] <= mem_wd[8*i +: 8];
        end
        if (mem_addr <= 32'd252)
            mem_rd <= {dbytes[b + 8'd3], dbytes[b + 8'd2], dbytes[b + 8'd1], dbytes[b]};
        else
            mem_rd <= 32'hBAD0BAD0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_starve;
    logic        e_crv, e_erv, e_cerr, e_eerr;
    logic [31:0] e_crd, e_erd;
    logic [7:0]  sh [0:255];

    function automatic bit legal_f(input logic [31:0] a);
        return (64'(a) + 64'd3) <= 64'(DEPTH - 1);
    endfunction

    // 0 = nobody, 1 = CPU, 2 = external
    function automatic int want_owner();
        if (ext_req && m_starve == STARVE_MAX) return 2;
        if (cpu_req) return 1;
        if (ext_req) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] sh_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {sh[b + 8'd3], sh[b + 8'd2], sh[b + 8'd1], sh[b]};
    endfunction

    always @(posedge clk or negedge arst_n) begin
        int          o;
        bit          lg, rd_ok;
        logic        w;
        logic [31:0] a, d;
        logic [7:0]  b;
        if (!arst_n) begin
            m_starve <= 0;
            e_crv <= 1'b0; e_erv <= 1'b0; e_cerr <= 1'b0; e_eerr <= 1'b0;
            e_crd <= 32'd0; e_erd <= 32'd0;
        end else begin
            o  = want_owner();
            a  = (o == 1) ? cpu_addr : ext_addr;
            d  = (o == 1) ? cpu_wd : ext_wd;
            w  = (o == 1) ? cpu_we : ext_we;
            lg = legal_f(a);
            rd_ok = (o != 0) && !w;
            if (ext_req && o != 2) m_starve <= (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
            else                   m_starve <= 0;
            e_crv  <= rd_ok && o == 1;
            e_erv  <= rd_ok && o == 2;
            e_crd  <= (rd_ok && o == 1 && lg) ? sh_word(a) : 32'd0;
            e_erd  <= (rd_ok && o == 2 && lg) ? sh_word(a) : 32'd0;
            e_cerr <= (o == 1) && !lg;
            e_eerr <= (o == 2) && !lg;
            if (o != 0 && w && lg) begin
                b = a[7:0];
                for (int i = 0; i < 4; i++) sh[b + 8'(i)] <= d[8*i +: 8];
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        int          o;
        logic [31:0] a, d;
        logic        w;
        if (run_cmp) begin
            o = want_owner();
            a = (o == 1) ? cpu_addr : (o == 2) ? ext_addr : 32'd0;
            d = (o == 1) ? cpu_wd : (o == 2) ? ext_wd : 32'd0;
            w = (o == 1) ? cpu_we : (o == 2) ? ext_we : 1'b0;
            chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && o != 1));
            chk("ext_gnt",    32'(ext_gnt),    32'(o == 2));
            chk("mem_addr",   mem_addr,        a);
            chk("mem_wd",     mem_wd,          d);
            chk("mem_we",     32'(mem_we),     32'(w && legal_f(a)));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
            chk("cpu_rd",     cpu_rd,          e_crd);
            chk("ext_rvalid", 32'(ext_rvalid), 32'(e_erv));
            chk("ext_rd",     ext_rd,          e_erd);
            chk("cpu_err",    32'(cpu_err),    32'(e_cerr));
            chk("ext_err",    32'(ext_err),    32'(e_eerr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wd = ed;
        $display("txn t=%0t cpu(req=%0b we=%0b a=%h d=%h) ext(req=%0b we=%0b a=%h d=%h)",
                 $time, cr, cw, ca, cd, er, ew, ea, ed);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        arst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wd = 32'd0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'd0; ext_wd = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
        chk("rst_errs",       32'({cpu_err, ext_err}), 32'd0);
        arst_n = 1'b1;

        // CPU store then load of the same word
        drv(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 chk("st_stall", 32'(cpu_stall), 32'd0);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        drv(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 chk("ld_stall", 32'(cpu_stall), 32'd0);
        idle();
        #2 chk("ld_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("ld_rd", cpu_rd, 32'hDEADBEEF);

        // External preload, read back by both requesters
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h11223344);
        #2 chk("pre_gnt", 32'(ext_gnt), 32'd1);
        drv(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
        #2 chk("pre_cpu_rd", cpu_rd, 32'h11223344);
        chk("pre_ext_gnt", 32'(ext_gnt), 32'd1);
        idle();
        #2 chk("pre_ext_rd", ext_rd, 32'h11223344);
        chk("pre_no_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

        // Starvation bound: forced external slot every fourth cycle
        for (int k = 0; k < 9; k++) begin
            drv(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
            #2 chk("starve_gnt", 32'(ext_gnt), 32'((k % 4) == 3));
            chk("starve_stall", 32'(cpu_stall), 32'((k % 4) == 3));
        end
        idle();

        // Range checks at the top of the array and a wrapped address
        drv(1'b1, 1'b1, 32'd116, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 chk("rng116_we", 32'(mem_we), 32'd1);
        drv(1'b1, 1'b1, 32'd117, 32'h0BADF00D, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 chk("rng117_we", 32'(mem_we), 32'd0);
        chk("rng117_stall", 32'(cpu_stall), 32'd0);
        drv(1'b1, 1'b0, 32'd116, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 chk("rng117_err", 32'(cpu_err), 32'd1);
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'd0);
        #2 chk("rng116_rd", cpu_rd, 32'hA5A5A5A5);
        chk("rng_err_once", 32'(cpu_err), 32'd0);
        idle();
        #2 chk("rng_ext_rvalid", 32'(ext_rvalid), 32'd1);
        chk("rng_ext_rd", ext_rd, 32'd0);
        chk("rng_ext_err", 32'(ext_err), 32'd1);

        // Back-to-back mixed reads keep order and steering
        drv(1'b1, 1'b1, 32'd0, 32'h01010101, 1'b0, 1'b0, 32'd0, 32'd0);
        drv(1'b1, 1'b1, 32'd4, 32'h04040404, 1'b0, 1'b0, 32'd0, 32'd0);
        drv(1'b1, 1'b1, 32'd8, 32'h08080808, 1'b0, 1'b0, 32'd0, 32'd0);
        drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0);
        #2 chk("b2b_cpu0", cpu_rd, 32'h01010101);
        chk("b2b_ext_quiet", 32'(ext_rvalid), 32'd0);
        drv(1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 chk("b2b_ext4", ext_rd, 32'h04040404);
        chk("b2b_cpu_quiet", 32'(cpu_rvalid), 32'd0);
        idle();
        #2 chk("b2b_cpu8", cpu_rd, 32'h08080808);
        chk("b2b_ext_quiet2", 32'(ext_rvalid), 32'd0);

        // Async reset in the middle of a load, with the starve count part-way up
        drv(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
        drv(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
        #2 chk("mid_gnt", 32'(ext_gnt), 32'd0);
        arst_n = 1'b0;
        #1 chk("mid_rst_rvalid", 32'({cpu_rvalid, ext_rvalid}), 32'd0);
        chk("mid_rst_err", 32'({cpu_err, ext_err}), 32'd0);
        chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
        idle();
        idle();
        arst_n = 1'b1;
        #2 chk("post_rst_rvalid", 32'(cpu_rvalid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
            #2 chk("post_rst_gnt", 32'(ext_gnt), 32'(k == 3));
        end
        idle();
        idle();

        @(posedge clk);
        #1;
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
